// File: rtl/uart_pkg.sv
// Shared UART definitions: baud table, FSM state encoding, done thresholds and CSR field positions.
// Imported by uart_tx, uart_baud_sel and the matching receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  localparam int NUM_BAUDS    = 8;
  localparam int BAUD_IDX_LSB = 16;
  localparam int BAUD_IDX_W   = 16;
  localparam int PARITY_BIT   = 0;
  localparam int NUM_THRESH   = 6;
  localparam int OVF_BIT      = 6;

  function automatic logic [31:0] baud_rate(input logic [2:0] idx);
    case (idx)
      3'd0:    return 32'd1200;
      3'd1:    return 32'd2400;
      3'd2:    return 32'd4800;
      3'd3:    return 32'd9600;
      3'd4:    return 32'd19200;
      3'd5:    return 32'd38400;
      3'd6:    return 32'd57600;
      default: return 32'd115200;
    endcase
  endfunction

  // Last cycle count of a bit period; the period itself is limit+1 clocks.
  function automatic logic [31:0] baud_limit(input logic [31:0] freq, input logic [2:0] idx);
    return freq / baud_rate(idx) - 32'd1;
  endfunction

  function automatic logic [5:0] done_thresh(input int k);
    case (k)
      0:       return 6'd1;
      1:       return 6'd2;
      2:       return 6'd3;
      3:       return 6'd8;
      4:       return 6'd16;
      default: return 6'd32;
    endcase
  endfunction

endpackage

// File: rtl/uart_baud_sel.sv
// Baud index to bit-period limit lookup; the table is folded to constants from FREQ.
module uart_baud_sel
  import uart_pkg::*;
#(
  parameter int unsigned FREQ = 50000000
) (
  input  logic [BAUD_IDX_W-1:0] baud_idx,
  output logic [31:0]           limit
);

  logic [31:0] limit_tbl [NUM_BAUDS];

  for (genvar gi = 0; gi < NUM_BAUDS; gi++) begin : g_limit
    assign limit_tbl[gi] = baud_limit(FREQ, 3'(gi));
  end

  // Out-of-range indices fall back to the fastest rate.
  always_comb begin
    if (baud_idx >= BAUD_IDX_W'(NUM_BAUDS)) limit = limit_tbl[NUM_BAUDS-1];
    else                                    limit = limit_tbl[baud_idx[2:0]];
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready byte input, 11-bit frame (start, 8 data LSB-first, parity, stop).
// Define UART_TX_FIFO_EN to replace the single holding register with a FIFO_DEPTH-entry FIFO.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned FREQ         = 50000000,
  parameter int          CONFIG_WIDTH = 32,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      din_valid,
  input  logic [7:0]                din,
  output logic                      din_ready,
  output logic                      tx,
  output logic                      busy,
  input  logic [CONFIG_WIDTH/2-1:0] enable,
  input  logic [CONFIG_WIDTH/2-1:0] clear,
  output logic                      done,
  output logic                      error,
  input  logic [CONFIG_WIDTH-1:0]   tx_conf
);

  localparam int EW = CONFIG_WIDTH / 2;

  uart_state_t           state_reg;
  logic                  tx_reg;
  logic [31:0]           baud_cnt_reg;
  logic [31:0]           limit_reg;
  logic [2:0]            bit_idx_reg;
  logic [7:0]            shift_reg;
  logic                  parity_reg;
  logic [5:0]            byte_cnt_reg;
  logic                  error_reg;
  logic [31:0]           limit_sel;
  logic                  bit_end;
  logic                  load;
  logic                  push;
  logic                  buf_empty;
  logic                  buf_full;
  logic [7:0]            buf_data;
  logic                  cnt_en;
  logic                  cnt_clr;
  logic                  cnt_inc;
  logic [NUM_THRESH-1:0] thresh_hit;
  logic                  unused_bits;

  uart_baud_sel #(.FREQ(FREQ)) u_baud_sel (
    .baud_idx (tx_conf[BAUD_IDX_LSB +: BAUD_IDX_W]),
    .limit    (limit_sel)
  );

  for (genvar gi = 0; gi < NUM_THRESH; gi++) begin : g_thresh
    assign thresh_hit[gi] = enable[gi] & (byte_cnt_reg == done_thresh(gi));
  end

  assign done      = |thresh_hit;
  assign din_ready = !buf_full & !done;
  assign push      = din_valid & din_ready;
  assign bit_end   = (baud_cnt_reg == limit_reg);
  // A pending byte starts a frame from idle or straight out of a finishing stop bit.
  assign load      = !buf_empty && ((state_reg == ST_IDLE) || (state_reg == ST_STOP && bit_end));
  assign busy      = (state_reg != ST_IDLE) | !buf_empty;
  assign tx        = tx_reg;
  assign error     = error_reg;

`ifdef UART_TX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (load) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, load})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: ;
      endcase
    end
  end

  assign buf_data  = fifo_mem[rd_ptr_reg];
  assign buf_empty = (count_reg == '0);
  assign buf_full  = (count_reg == (AW+1)'(FIFO_DEPTH));
`else
  logic        hold_valid_reg;
  logic [7:0]  hold_data_reg;
  logic [31:0] unused_depth;

  always_ff @(posedge clock) begin
    if (reset) begin
      hold_valid_reg <= 1'b0;
      hold_data_reg  <= '0;
    end else if (push) begin
      hold_valid_reg <= 1'b1;
      hold_data_reg  <= din;
    end else if (load) begin
      hold_valid_reg <= 1'b0;
    end
  end

  assign buf_data     = hold_data_reg;
  assign buf_empty    = !hold_valid_reg;
  assign buf_full     = hold_valid_reg;
  assign unused_depth = FIFO_DEPTH;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      tx_reg       <= 1'b1;
      baud_cnt_reg <= '0;
      limit_reg    <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
      parity_reg   <= 1'b0;
    end else if (load) begin
      // Rate and parity are captured here and held until this frame's stop bit ends.
      state_reg    <= ST_START;
      tx_reg       <= 1'b0;
      baud_cnt_reg <= '0;
      limit_reg    <= limit_sel;
      shift_reg    <= buf_data;
      parity_reg   <= tx_conf[PARITY_BIT] ? ~^buf_data : ^buf_data;
    end else begin
      baud_cnt_reg <= bit_end ? '0 : baud_cnt_reg + 32'd1;
      case (state_reg)
        ST_IDLE: begin
          tx_reg       <= 1'b1;
          baud_cnt_reg <= '0;
        end
        ST_START: if (bit_end) begin
          state_reg   <= ST_DATA;
          tx_reg      <= shift_reg[0];
          bit_idx_reg <= '0;
        end
        ST_DATA: if (bit_end) begin
          if (bit_idx_reg == 3'd7) begin
            state_reg <= ST_PARITY;
            tx_reg    <= parity_reg;
          end else begin
            bit_idx_reg <= bit_idx_reg + 3'd1;
            shift_reg   <= shift_reg >> 1;
            tx_reg      <= shift_reg[1];
          end
        end
        ST_PARITY: if (bit_end) begin
          state_reg <= ST_STOP;
          tx_reg    <= 1'b1;
        end
        ST_STOP: if (bit_end) begin
          state_reg <= ST_IDLE;
          tx_reg    <= 1'b1;
        end
        default: begin
          state_reg <= ST_IDLE;
          tx_reg    <= 1'b1;
        end
      endcase
    end
  end

  assign cnt_en  = |enable[NUM_THRESH-1:0];
  assign cnt_clr = cnt_en & (|clear[NUM_THRESH-1:0]);
  assign cnt_inc = cnt_en & !done & (state_reg == ST_STOP) & bit_end;

  always_ff @(posedge clock) begin
    if (reset || cnt_clr) byte_cnt_reg <= '0;
    else if (cnt_inc)     byte_cnt_reg <= byte_cnt_reg + 6'd1;
  end

  always_ff @(posedge clock) begin
    if (reset || !enable[OVF_BIT])      error_reg <= 1'b0;
    else if (clear[OVF_BIT])            error_reg <= 1'b0;
    else if (din_valid && !din_ready)   error_reg <= 1'b1;
  end

  assign unused_bits = ^{tx_conf[BAUD_IDX_LSB-1:PARITY_BIT+1], enable[EW-1:OVF_BIT+1],
                         clear[EW-1:OVF_BIT+1]};

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: table of single frames, then back-to-back, done, error and reset sequences.
module tb_uart_tx;

  localparam int unsigned FREQ     = 460800;
  localparam logic [31:0] CHG_CONF = {16'd6, 15'd0, 1'b1};

  logic        clock = 1'b0;
  logic        reset;
  logic        din_valid;
  logic [7:0]  din;
  logic        din_ready;
  logic        tx;
  logic        busy;
  logic [15:0] enable;
  logic [15:0] clear;
  logic        done;
  logic        error;
  logic [31:0] tx_conf;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  uart_tx #(.FREQ(FREQ), .CONFIG_WIDTH(32), .FIFO_DEPTH(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .din_valid (din_valid),
    .din       (din),
    .din_ready (din_ready),
    .tx        (tx),
    .busy      (busy),
    .enable    (enable),
    .clear     (clear),
    .done      (done),
    .error     (error),
    .tx_conf   (tx_conf)
  );

  typedef struct {
    logic [7:0]  data;
    logic [15:0] idx;
    logic        odd;
    int          period;
    logic [10:0] frame;
    logic        chg;
  } vec_t;

  vec_t vecs [13];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [10:0] exp_frame(input logic [7:0] b, input logic odd);
    logic p;
    p = odd ? ~^b : ^b;
    return {1'b1, p, b, 1'b0};
  endfunction

  // Offer a byte and return right after the accepting edge.
  task automatic send(input logic [7:0] b);
    int guard = 0;
    din       = b;
    din_valid = 1'b1;
    while (!din_ready && guard < 2000) begin
      tick();
      guard++;
    end
    if (!din_ready) check("ready_wait", {31'd0, din_ready}, 32'd1);
    tick();
    din_valid = 1'b0;
  endtask

  // Sample tx once per cycle for nfr frames; bit value is the first sample of each period.
  task automatic capture(input int nfr, input int p, input logic pend, input logic [7:0] pend_byte,
                         input logic chg, output logic [21:0] got, output int gl,
                         output logic busy_last);
    logic acc;
    got       = '0;
    gl        = 0;
    busy_last = 1'b0;
    if (pend) begin
      din       = pend_byte;
      din_valid = 1'b1;
    end
    for (int c = 0; c < nfr * 11 * p; c++) begin
      if (chg && c == p) tx_conf = CHG_CONF;
      if (c % p == 0) got[c / p] = tx;
      else if (tx !== got[c / p]) gl++;
      if (c == nfr * 11 * p - 1) busy_last = busy;
      acc = din_valid && din_ready;
      tick();
      if (acc) din_valid = 1'b0;
    end
    din_valid = 1'b0;
  endtask

  task automatic do_frame(input string nm, input logic [7:0] b, input logic [15:0] idx,
                          input logic odd, input int p, input logic [10:0] exp, input logic chg);
    logic [21:0] got;
    int          gl;
    logic        bl;
    tx_conf = {idx, 15'd0, odd};
    send(b);
    check({nm, "_held"}, {31'd0, tx}, 32'd1);
    tick();
    check({nm, "_start"}, {31'd0, tx}, 32'd0);
    capture(1, p, 1'b0, 8'h00, chg, got, gl, bl);
    check({nm, "_frame"}, {21'd0, got[10:0]}, {21'd0, exp});
    check({nm, "_glitch"}, gl, 0);
    check({nm, "_busy_last"}, {31'd0, bl}, 32'd1);
    check({nm, "_busy_end"}, {31'd0, busy}, 32'd0);
    check({nm, "_tx_idle"}, {31'd0, tx}, 32'd1);
  endtask

  initial begin
    logic [21:0] got;
    int          gl;
    logic        bl;
    logic        seen;

    // Frames written out as {stop, parity, data, start}; parity worked out by hand.
    vecs[0]  = '{8'h55, 16'd7,      1'b0, 4,   {1'b1, 1'b0, 8'h55, 1'b0}, 1'b0};
    vecs[1]  = '{8'h01, 16'd7,      1'b1, 4,   {1'b1, 1'b0, 8'h01, 1'b0}, 1'b0};
    vecs[2]  = '{8'h01, 16'd7,      1'b0, 4,   {1'b1, 1'b1, 8'h01, 1'b0}, 1'b0};
    vecs[3]  = '{8'h55, 16'd7,      1'b0, 4,   {1'b1, 1'b0, 8'h55, 1'b0}, 1'b1};
    vecs[4]  = '{8'h00, 16'd0,      1'b0, 384, {1'b1, 1'b0, 8'h00, 1'b0}, 1'b0};
    vecs[5]  = '{8'hFF, 16'd1,      1'b1, 192, {1'b1, 1'b1, 8'hFF, 1'b0}, 1'b0};
    vecs[6]  = '{8'hA3, 16'd2,      1'b0, 96,  {1'b1, 1'b0, 8'hA3, 1'b0}, 1'b0};
    vecs[7]  = '{8'h3C, 16'd4,      1'b1, 24,  {1'b1, 1'b1, 8'h3C, 1'b0}, 1'b0};
    vecs[8]  = '{8'h80, 16'd5,      1'b0, 12,  {1'b1, 1'b1, 8'h80, 1'b0}, 1'b0};
    vecs[9]  = '{8'h7E, 16'd6,      1'b1, 8,   {1'b1, 1'b1, 8'h7E, 1'b0}, 1'b0};
    vecs[10] = '{8'h96, 16'd9,      1'b0, 4,   {1'b1, 1'b0, 8'h96, 1'b0}, 1'b0};
    vecs[11] = '{8'h0F, 16'd3,      1'b1, 48,  {1'b1, 1'b1, 8'h0F, 1'b0}, 1'b0};
    vecs[12] = '{8'hC1, 16'hFFFF,   1'b0, 4,   {1'b1, 1'b1, 8'hC1, 1'b0}, 1'b0};

    reset     = 1'b1;
    din_valid = 1'b0;
    din       = 8'h00;
    enable    = 16'h0000;
    clear     = 16'h0000;
    tx_conf   = {16'd7, 15'd0, 1'b0};
    repeat (3) tick();
    check("rst_tx",    {31'd0, tx},        32'd1);
    check("rst_ready", {31'd0, din_ready}, 32'd1);
    check("rst_busy",  {31'd0, busy},      32'd0);
    check("rst_done",  {31'd0, done},      32'd0);
    check("rst_error", {31'd0, error},     32'd0);
    reset  = 1'b0;
    enable = 16'h003F;
    tick();
    check("rst_done_all_en", {31'd0, done}, 32'd0);
    enable = 16'h0000;
    tick();

    for (int i = 0; i < 13; i++) begin
      $display("vec %0d: data=%02h idx=%0d odd=%0d period=%0d", i, vecs[i].data, vecs[i].idx,
               vecs[i].odd, vecs[i].period);
      do_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].idx, vecs[i].odd, vecs[i].period,
               vecs[i].frame, vecs[i].chg);
    end

    // Back-to-back at 9600 baud: second start bit directly after first stop bit.
    tx_conf = {16'd3, 15'd0, 1'b0};
    send(8'hA3);
    tick();
    check("b2b_start", {31'd0, tx}, 32'd0);
    capture(2, 48, 1'b1, 8'h3C, 1'b0, got, gl, bl);
    check("b2b_frames", {10'd0, got}, {10'd0, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, 8'hA3, 1'b0});
    check("b2b_glitch", gl, 0);
    check("b2b_busy_last", {31'd0, bl}, 32'd1);
    check("b2b_busy_end", {31'd0, busy}, 32'd0);
    $display("b2b: frames=%06h", got);

    // Threshold 8: done after the eighth stop bit, ninth byte refused.
    enable = 16'h0008;
    tick();
    for (int k = 1; k <= 8; k++) begin
      do_frame($sformatf("cnt%0d", k), 8'(k * 17), 16'd7, 1'b0, 4, exp_frame(8'(k * 17), 1'b0), 1'b0);
      check($sformatf("done_after_%0d", k), {31'd0, done}, {31'd0, k == 8});
    end
    check("done_ready", {31'd0, din_ready}, 32'd0);
    din       = 8'h99;
    din_valid = 1'b1;
    seen      = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (busy || !tx) seen = 1'b1;
    end
    din_valid = 1'b0;
    check("ninth_refused", {31'd0, seen}, 32'd0);
    check("ninth_no_error", {31'd0, error}, 32'd0);
    clear = 16'h0008;
    tick();
    clear = 16'h0000;
    check("cnt_clear_done", {31'd0, done}, 32'd0);
    check("cnt_clear_ready", {31'd0, din_ready}, 32'd1);
    $display("done8: cleared done=%0d ready=%0d", done, din_ready);

    // Threshold 1: byte already held is still sent but not counted, so done stays set.
    enable  = 16'h0001;
    tx_conf = {16'd7, 15'd0, 1'b0};
    tick();
    check("t1_done_init", {31'd0, done}, 32'd0);
    send(8'h11);
    tick();
    capture(2, 4, 1'b1, 8'h22, 1'b0, got, gl, bl);
    check("t1_frames", {10'd0, got}, {10'd0, exp_frame(8'h22, 1'b0), exp_frame(8'h11, 1'b0)});
    check("t1_glitch", gl, 0);
    check("t1_done", {31'd0, done}, 32'd1);
    clear = 16'h0001;
    tick();
    clear  = 16'h0000;
    check("t1_cleared", {31'd0, done}, 32'd0);
    enable = 16'h0000;
    $display("t1: frames=%06h", got);

    // Overflow flag: set, sticky, clear priority, held low while disabled.
    enable = 16'h0040;
    tick();
    send(8'h33);
    tick();
    din       = 8'h44;
    din_valid = 1'b1;
    check("err_ready_free", {31'd0, din_ready}, 32'd1);
    tick();
    din = 8'h55;
    check("err_ready_full", {31'd0, din_ready}, 32'd0);
    check("err_before", {31'd0, error}, 32'd0);
    tick();
    check("err_set", {31'd0, error}, 32'd1);
    din_valid = 1'b0;
    repeat (5) tick();
    check("err_sticky", {31'd0, error}, 32'd1);
    clear     = 16'h0040;
    din_valid = 1'b1;
    tick();
    check("err_clr_prio", {31'd0, error}, 32'd0);
    clear = 16'h0000;
    tick();
    check("err_reset", {31'd0, error}, 32'd1);
    enable = 16'h0000;
    tick();
    check("err_disabled", {31'd0, error}, 32'd0);
    din_valid = 1'b0;
    for (int i = 0; i < 500 && busy; i++) tick();
    check("err_drain", {31'd0, busy}, 32'd0);
    $display("error: sequence complete, error=%0d", error);

    // Every byte value, alternating rate and parity.
    for (int b = 0; b < 256; b++) begin
      logic [7:0] bv;
      logic       odd;
      int         p;
      bv      = 8'(b);
      odd     = bv[1];
      p       = bv[0] ? 8 : 4;
      tx_conf = {(bv[0] ? 16'd6 : 16'd7), 15'd0, odd};
      send(bv);
      tick();
      capture(1, p, 1'b0, 8'h00, 1'b0, got, gl, bl);
      check($sformatf("loop_%02h", bv), {20'd0, gl != 0, got[10:0]},
            {20'd0, 1'b0, exp_frame(bv, odd)});
      $display("loop: byte=%02h frame=%03h", bv, got[10:0]);
    end

    // Reset in the middle of a slow start bit.
    tx_conf = {16'd0, 15'd0, 1'b0};
    send(8'h00);
    tick();
    repeat (50) tick();
    check("midrst_low", {31'd0, tx}, 32'd0);
    reset = 1'b1;
    tick();
    check("midrst_tx", {31'd0, tx}, 32'd1);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_ready", {31'd0, din_ready}, 32'd1);
    reset = 1'b0;
    repeat (5) tick();
    check("midrst_tx_after", {31'd0, tx}, 32'd1);
    check("midrst_busy_after", {31'd0, busy}, 32'd0);
    $display("reset: mid-frame abort tx=%0d busy=%0d", tx, busy);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
